ucitavanje_uzorka: RTL and testbench

UCITAVANJE_UZORKA -- requirements
Module: ucitavanje_uzorka

---
 rtl/ucitavanje_uzorka_if.sv | 24 ++
 rtl/ucitavanje_uzorka.sv | 77 +++++++
 tb/tb_ucitavanje_uzorka.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/ucitavanje_uzorka_if.sv
// Handshake bundle for the sample loader: word-serial ingress stream and
// frame-parallel egress towards the neuron layer.
interface ucitavanje_uzorka_if #(
    parameter int BROJ_ZNACAJKI = 60,
    parameter int SIRINA        = 16
);
    logic [SIRINA-1:0]               ulaz_podatak;
    logic                            ulaz_valid;
    logic                            ulaz_sof;
    logic                            ulaz_ready;
    logic [BROJ_ZNACAJKI*SIRINA-1:0] uzorak;
    logic                            uzorak_valid;
    logic                            uzorak_ready;

    modport master (
        output ulaz_podatak, ulaz_valid, ulaz_sof, uzorak_ready,
        input  ulaz_ready, uzorak, uzorak_valid
    );

    modport slave (
        input  ulaz_podatak, ulaz_valid, ulaz_sof, uzorak_ready,
        output ulaz_ready, uzorak, uzorak_valid
    );
endinterface

// File: rtl/ucitavanje_uzorka.sv
// Sample loader: gathers BROJ_ZNACAJKI feature words into one wide vector,
// resynchronises on start-of-frame and holds the frame until it is consumed.
module ucitavanje_uzorka #(
    parameter int BROJ_ZNACAJKI = 60,
    parameter int SIRINA        = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    ucitavanje_uzorka_if.slave   bus,
    output logic                 greska_okvira,
    output logic [15:0]          broj_okvira
);
    typedef enum logic {
        PRIJEM = 1'b0,
        PUN    = 1'b1
    } stanje_t;

    localparam int         SIRINA_UZORKA = BROJ_ZNACAJKI * SIRINA;
    localparam logic [5:0] ZADNJI        = 6'(BROJ_ZNACAJKI - 1);

    stanje_t                  stanje;
    logic [5:0]               idx;
    logic [SIRINA_UZORKA-1:0] uzorak;
    logic                     uzorak_valid;

    // Ready comes straight from the state register so the upstream source
    // never sees a combinational path through this block.
    assign bus.ulaz_ready   = (stanje == PRIJEM);
    assign bus.uzorak       = uzorak;
    assign bus.uzorak_valid = uzorak_valid;

    // NOTE: every register here uses non-blocking assignment, so all reads in
    // this block see the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stanje        <= PRIJEM;
            idx           <= '0;
            // NOTE: the wide sample register is deliberately reset so a frame
            // cut short by reset can never leak stale features downstream.
            uzorak        <= '0;
            uzorak_valid  <= 1'b0;
            greska_okvira <= 1'b0;
            broj_okvira   <= '0;
        end else begin
            greska_okvira <= 1'b0;
            case (stanje)
                PRIJEM: begin
                    if (bus.ulaz_valid) begin
                        if (bus.ulaz_sof) begin
                            // Start-of-frame always restarts at slot 0; a
                            // partially filled frame is abandoned and flagged.
                            uzorak[SIRINA-1:0] <= bus.ulaz_podatak;
                            idx                <= 6'd1;
                            greska_okvira      <= (idx != '0);
                        end else begin
                            uzorak[int'(idx)*SIRINA +: SIRINA] <= bus.ulaz_podatak;
                            if (idx == ZADNJI) begin
                                idx          <= '0;
                                stanje       <= PUN;
                                uzorak_valid <= 1'b1;
                            end else begin
                                idx <= idx + 6'd1;
                            end
                        end
                    end
                end
                PUN: begin
                    if (bus.uzorak_ready) begin
                        stanje       <= PRIJEM;
                        uzorak_valid <= 1'b0;
                        broj_okvira  <= broj_okvira + 16'd1;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ucitavanje_uzorka.sv
// Self-checking bench for ucitavanje_uzorka: behavioural frame model feeding a
// scoreboard queue, a short vector table and directed multi-cycle sequences.
module tb_ucitavanje_uzorka;
    localparam int N = 60;
    localparam int S = 16;
    localparam int W = N * S;

    logic         clk;
    logic         rst_n;
    logic         greska_okvira;
    logic [15:0]  broj_okvira;

    ucitavanje_uzorka_if #(.BROJ_ZNACAJKI(N), .SIRINA(S)) bus ();

    ucitavanje_uzorka #(.BROJ_ZNACAJKI(N), .SIRINA(S)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus           (bus),
        .greska_okvira (greska_okvira),
        .broj_okvira   (broj_okvira)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural model of the loader
    int          m_idx;
    bit          m_full;
    bit          m_err;
    logic [15:0] m_cnt;
    logic [W-1:0] m_frame;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] held;
    bit          dut_valid_prev;

    typedef struct {
        logic        v;
        logic        s;
        logic [15:0] d;
        logic        exp_ready;
        logic        exp_valid;
        logic        exp_err;
    } vec_t;

    vec_t tab[8];

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // One clock cycle: drive at posedge+1, check ready at negedge, advance the
    // model at the edge and compare registered outputs just after it.
    task automatic step(input logic v, input logic s, input logic [15:0] d, input logic r);
        bus.ulaz_valid   = v;
        bus.ulaz_sof     = s;
        bus.ulaz_podatak = d;
        bus.uzorak_ready = r;
        @(negedge clk);
        check("ulaz_ready", bus.ulaz_ready, !m_full);
        @(posedge clk);
        m_err = 1'b0;
        if (!m_full) begin
            if (v) begin
                if (s) begin
                    m_err = (m_idx != 0);
                    m_frame[S-1:0] = d;
                    m_idx = 1;
                end else begin
                    m_frame[m_idx*S +: S] = d;
                    if (m_idx == N - 1) begin
                        m_idx  = 0;
                        m_full = 1'b1;
                        exp_q.push_back(m_frame);
                    end else begin
                        m_idx++;
                    end
                end
            end
        end else if (r) begin
            m_full = 1'b0;
            m_cnt  = m_cnt + 16'd1;
        end
        #1;
        check("uzorak_valid", bus.uzorak_valid, m_full);
        check("greska_okvira", greska_okvira, m_err);
        check("broj_okvira", broj_okvira, m_cnt);
        if (bus.uzorak_valid && !dut_valid_prev) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_frame", 1'b1, 1'b0);
            end else begin
                held = exp_q.pop_front();
                check("frame", bus.uzorak, held);
            end
        end else if (bus.uzorak_valid) begin
            check("frame_hold", bus.uzorak, held);
        end
        dut_valid_prev = bus.uzorak_valid;
    endtask

    task automatic send_words(input int n, input logic first_sof, input logic [15:0] base, input logic r);
        for (int k = 0; k < n; k++)
            step(1'b1, (k == 0) ? first_sof : 1'b0, base + 16'(k), r);
    endtask

    // Asynchronous reset mid-cycle; outputs must clear before the next edge.
    task automatic do_reset();
        bus.ulaz_valid   = 1'b0;
        bus.ulaz_sof     = 1'b0;
        bus.uzorak_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_ulaz_ready", bus.ulaz_ready, 1'b1);
        check("rst_uzorak_valid", bus.uzorak_valid, 1'b0);
        check("rst_uzorak", bus.uzorak, '0);
        check("rst_greska", greska_okvira, 1'b0);
        check("rst_broj", broj_okvira, 16'd0);
        m_idx = 0; m_full = 1'b0; m_err = 1'b0; m_cnt = '0;
        m_frame = '0; held = '0; dut_valid_prev = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        tab[0] = '{1'b1, 1'b1, 16'hAAAA, 1'b1, 1'b0, 1'b0};
        tab[1] = '{1'b1, 1'b0, 16'h1111, 1'b1, 1'b0, 1'b0};
        tab[2] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0};
        tab[3] = '{1'b1, 1'b1, 16'hBBBB, 1'b1, 1'b0, 1'b1};
        tab[4] = '{1'b1, 1'b0, 16'h2222, 1'b1, 1'b0, 1'b0};
        tab[5] = '{1'b1, 1'b1, 16'hCCCC, 1'b1, 1'b0, 1'b1};
        tab[6] = '{1'b1, 1'b1, 16'hDDDD, 1'b1, 1'b0, 1'b1};
        tab[7] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0};

        rst_n = 1'b0;
        bus.ulaz_valid = 1'b0; bus.ulaz_sof = 1'b0;
        bus.ulaz_podatak = '0; bus.uzorak_ready = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        // Resynchronisation vectors: sof at idx 0 is silent, elsewhere pulses
        for (int i = 0; i < 8; i++) begin
            step(tab[i].v, tab[i].s, tab[i].d, 1'b0);
            check($sformatf("tab%0d_ready", i), bus.ulaz_ready, tab[i].exp_ready);
            check($sformatf("tab%0d_valid", i), bus.uzorak_valid, tab[i].exp_valid);
            check($sformatf("tab%0d_err", i), greska_okvira, tab[i].exp_err);
        end
        do_reset();

        // Basic frame with an always-ready consumer
        send_words(N, 1'b1, 16'h0100, 1'b1);
        check("f1_valid", bus.uzorak_valid, 1'b1);
        check("f1_slot0", bus.uzorak[15:0], 16'h0100);
        check("f1_slot59", bus.uzorak[959:944], 16'h013B);
        step(1'b0, 1'b0, 16'h0000, 1'b1);
        check("f1_broj", broj_okvira, 16'd1);

        // Stalled consumer: 10 cycles of offered words must not be accepted
        send_words(N, 1'b1, 16'h0400, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 16'h5555, 1'b0);
        check("stall_slot0", bus.uzorak[15:0], 16'h0400);
        step(1'b1, 1'b0, 16'h5555, 1'b1);
        check("handshake_no_accept", bus.ulaz_ready, 1'b1);
        send_words(N, 1'b1, 16'h5555, 1'b1);
        check("after_stall_slot0", bus.uzorak[15:0], 16'h5555);
        step(1'b0, 1'b0, 16'h0000, 1'b1);
        check("after_stall_broj", broj_okvira, 16'd3);
        do_reset();

        // Early sof after 20 words aborts the frame
        send_words(20, 1'b1, 16'h0200, 1'b1);
        step(1'b1, 1'b1, 16'hAAAA, 1'b1);
        check("abort_pulse", greska_okvira, 1'b1);
        send_words(N - 2, 1'b0, 16'h0301, 1'b1);
        check("abort_not_yet_valid", bus.uzorak_valid, 1'b0);
        step(1'b1, 1'b0, 16'h03FF, 1'b1);
        check("abort_valid", bus.uzorak_valid, 1'b1);
        check("abort_slot0", bus.uzorak[15:0], 16'hAAAA);
        step(1'b0, 1'b0, 16'h0000, 1'b1);

        // Asynchronous reset at word 30, then a fresh frame
        send_words(30, 1'b1, 16'h0600, 1'b1);
        do_reset();
        send_words(N, 1'b0, 16'h0700, 1'b1);
        check("post_reset_slot0", bus.uzorak[15:0], 16'h0700);
        step(1'b0, 1'b0, 16'h0000, 1'b1);
        check("post_reset_broj", broj_okvira, 16'd1);
        do_reset();

        // Random valid (50%) and consumer readiness over three frames
        begin
            int cyc = 0;
            while (m_cnt != 16'd3 && cyc < 3000) begin
                step(1'($urandom_range(0, 1)), 1'b0, 16'($urandom),
                     1'($urandom_range(0, 3) != 0));
                cyc++;
            end
        end
        check("rand_broj", broj_okvira, 16'd3);

        // Counter wrap from 0xFFFF
        bus.ulaz_valid = 1'b0;
        force dut.broj_okvira = 16'hFFFF;
        #1;
        release dut.broj_okvira;
        m_cnt = 16'hFFFF;
        send_words(N, 1'b1, 16'h0900, 1'b1);
        check("wrap_pre", broj_okvira, 16'hFFFF);
        step(1'b0, 1'b0, 16'h0000, 1'b1);
        check("wrap_broj", broj_okvira, 16'h0000);

        check("sb_drained", W'(exp_q.size()), '0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
